servo_pulse_encoder: RTL



---
 rtl/servo_pkg.sv | 20 ++
 rtl/servo_sync_edge.sv | 32 +++
 rtl/servo_pulse_encoder.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/servo_pkg.sv
// Shared servo constants and FSM state type, used by both the angle-to-width
// decoder and the width-to-angle encoder.
package servo_pkg;

  localparam int unsigned OFFSET_DEF  = 100000;
  localparam int unsigned STEP_DEF    = 555;
  localparam int unsigned TIMEOUT_DEF = 2500000;
  localparam int unsigned CNT_W_DEF   = 22;
  localparam int unsigned ANGLE_W     = 8;
  localparam int unsigned WIDTH_W     = 21;

  typedef enum logic [2:0] {
    IDLE,
    HIGH,
    CONV,
    DONE,
    WAIT_LOW
  } servo_state_e;

endpackage

// File: rtl/servo_sync_edge.sv
// Two-flop synchronizer for an asynchronous input, plus single-cycle
// rise/fall strobes derived from the synchronized level.
module servo_sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic async_in,
  output logic level,
  output logic rise,
  output logic fall
);

  logic meta;
  logic sync;
  logic prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b0;
      sync <= 1'b0;
      prev <= 1'b0;
    end else begin
      meta <= async_in;
      sync <= meta;
      prev <= sync;
    end
  end

  assign level = sync;
  assign rise  = sync & ~prev;
  assign fall  = ~sync & prev;

endmodule

// File: rtl/servo_pulse_encoder.sv
// Measures servo PWM high-time and recovers angle = round((width-OFFSET)/STEP).
// Optional SERVO_ENC_AGREE_EN: publish only when two consecutive conversions agree.
module servo_pulse_encoder
  import servo_pkg::*;
#(
  parameter int unsigned OFFSET      = OFFSET_DEF,
  parameter int unsigned STEP        = STEP_DEF,
  parameter int unsigned TIMEOUT_CYC = TIMEOUT_DEF,
  parameter int unsigned CNT_W       = CNT_W_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               pwm_in,
  output logic [ANGLE_W-1:0] angle_out,
  output logic               angle_valid,
  output logic [WIDTH_W-1:0] width_out,
  output logic               range_err,
  output logic               stuck_err,
  output logic               signal_lost
);

  localparam logic [CNT_W-1:0] OFFSET_C  = CNT_W'(OFFSET);
  localparam logic [CNT_W-1:0] STEP_C    = CNT_W'(STEP);
  localparam logic [CNT_W-1:0] HALF_C    = CNT_W'(STEP / 2);
  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT_CYC);
  localparam logic [ANGLE_W-1:0] ANGLE_MAX = '1;

  logic               level;
  logic               rise;
  logic               fall;
  servo_state_e       state;
  servo_state_e       state_nxt;
  logic [CNT_W-1:0]   width_cnt;
  logic [CNT_W-1:0]   idle_cnt;
  logic [CNT_W-1:0]   width_q;
  logic [CNT_W-1:0]   rem;
  logic [ANGLE_W-1:0] quot;
  logic               range_flag;
  logic               conv_init;
  logic               conv_step;
  logic               clamp;

`ifdef SERVO_ENC_AGREE_EN
  logic [ANGLE_W-1:0] cand_q;
  logic               cand_valid;
`endif

  servo_sync_edge u_sync (
    .clk      (clk),
    .rst_n    (rst_n),
    .async_in (pwm_in),
    .level    (level),
    .rise     (rise),
    .fall     (fall)
  );

  assign conv_step = (rem >= STEP_C) && (quot != ANGLE_MAX);
  assign clamp     = (rem >= STEP_C);
  assign width_out = width_q[WIDTH_W-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (rise) state_nxt = HIGH;
      HIGH: begin
        if (fall)                         state_nxt = CONV;
        else if (width_cnt >= TIMEOUT_C)  state_nxt = WAIT_LOW;
      end
      CONV:     if (!conv_init && !conv_step) state_nxt = DONE;
      DONE:     state_nxt = IDLE;
      WAIT_LOW: if (!level) state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  // Result strobes are loaded on the CONV->DONE edge so they are visible
  // exactly during the DONE cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      width_cnt   <= '0;
      idle_cnt    <= '0;
      width_q     <= '0;
      rem         <= '0;
      quot        <= '0;
      range_flag  <= 1'b0;
      conv_init   <= 1'b0;
      angle_out   <= '0;
      angle_valid <= 1'b0;
      range_err   <= 1'b0;
      stuck_err   <= 1'b0;
      signal_lost <= 1'b0;
`ifdef SERVO_ENC_AGREE_EN
      cand_q      <= '0;
      cand_valid  <= 1'b0;
`endif
    end else begin
      angle_valid <= 1'b0;
      range_err   <= 1'b0;
      stuck_err   <= 1'b0;
      case (state)
        IDLE: begin
          if (rise) begin
            width_cnt   <= CNT_W'(1);
            idle_cnt    <= '0;
            signal_lost <= 1'b0;
          end else if (idle_cnt != TIMEOUT_C) begin
            idle_cnt <= idle_cnt + 1'b1;
            if (idle_cnt == TIMEOUT_C - 1'b1) begin
              signal_lost <= 1'b1;
`ifdef SERVO_ENC_AGREE_EN
              cand_valid  <= 1'b0;
`endif
            end
          end
        end
        HIGH: begin
          if (fall) begin
            width_q   <= width_cnt;
            conv_init <= 1'b1;
          end else if (width_cnt >= TIMEOUT_C) begin
            stuck_err  <= 1'b1;
`ifdef SERVO_ENC_AGREE_EN
            cand_valid <= 1'b0;
`endif
          end else begin
            width_cnt <= width_cnt + 1'b1;
          end
        end
        CONV: begin
          if (conv_init) begin
            conv_init <= 1'b0;
            quot      <= '0;
            if (width_q < OFFSET_C) begin
              rem        <= '0;
              range_flag <= 1'b1;
            end else begin
              rem        <= width_q - OFFSET_C + HALF_C;
              range_flag <= 1'b0;
            end
          end else if (conv_step) begin
            rem  <= rem - STEP_C;
            quot <= quot + 1'b1;
          end else begin
`ifdef SERVO_ENC_AGREE_EN
            cand_q     <= quot;
            cand_valid <= 1'b1;
            if (cand_valid && (cand_q == quot)) begin
              angle_out   <= quot;
              angle_valid <= 1'b1;
              range_err   <= range_flag | clamp;
            end
`else
            angle_out   <= quot;
            angle_valid <= 1'b1;
            range_err   <= range_flag | clamp;
`endif
          end
        end
        default: ;
      endcase
    end
  end

endmodule
